// File: rtl/keypad_pkg.sv
// keypad_pkg: frame classification, control states and a constant clog2 helper.
package keypad_pkg;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
  typedef enum logic [1:0] {ST_SCAN, ST_EVAL, ST_PEND} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchroniser; resets to all ones, the idle level of active-low senses.
module keypad_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed key matrix scanner with frame debounce and press/release events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int CLK_HZ          = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 8,
  localparam int CODE_W         = clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_press,
  output logic              key_release,
  output logic              multi_key
);
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = clog2(DWELL);
  localparam int ROW_W = clog2(ROWS);
  localparam int SW    = clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0]    DEB      = SW'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_e            state_q, state_d;
  cls_e              pcls_q, pcls_d, acls_q, acls_d, f_cls;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        nk_q, nk_d;
  logic [4:0]        nk_sum;
  logic [3:0]        n_row;
  logic [CODE_W-1:0] fc_q, fc_d, pcode_q, pcode_d, acode_q, acode_d, code_q, code_d;
  logic [CODE_W-1:0] f_code, row_code;
  logic [SW-1:0]     stab_q, stab_d, stab_n;
  logic [COLS-1:0]   col_s;
  logic              run_q, press_q, press_d, rel_q, rel_d;
  logic              sample, eval, match, upd, new_press, roll;

  keypad_sync #(.W(COLS)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(col_n), .q_o(col_s));

  // Scanning the row from the top column down leaves the lowest low column as the row's code.
  always_comb begin
    n_row    = '0;
    row_code = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (!col_s[c]) begin
        n_row    = n_row + 4'd1;
        row_code = CODE_W'(int'(row_q) * COLS + c);
      end
  end

  assign sample    = state_q == ST_SCAN && cnt_q == LAST_CNT;
  assign eval      = state_q == ST_EVAL;
  assign nk_sum    = {3'b0, nk_q} + {1'b0, n_row};
  assign nk_d      = sample ? (nk_sum >= 5'd2 ? 2'd2 : nk_sum[1:0]) : eval ? 2'd0 : nk_q;
  assign fc_d      = (sample && nk_q == 2'd0 && n_row != 4'd0) ? row_code : eval ? '0 : fc_q;
  assign f_cls     = nk_q == 2'd0 ? CLS_NONE : nk_q == 2'd1 ? CLS_SINGLE : CLS_MULTI;
  assign f_code    = nk_q == 2'd1 ? fc_q : '0;
  assign match     = f_cls == pcls_q && f_code == pcode_q;
  assign stab_n    = !match ? SW'(1) : stab_q == DEB ? DEB : stab_q + SW'(1);
  assign upd       = eval && stab_n == DEB && (f_cls != acls_q || f_code != acode_q);
  assign new_press = upd && f_cls == CLS_SINGLE && acls_q != CLS_SINGLE;
  assign roll      = upd && f_cls == CLS_SINGLE && acls_q == CLS_SINGLE;
  assign press_d   = new_press || state_q == ST_PEND;
  assign rel_d     = upd && acls_q == CLS_SINGLE;
  // On a roll the accepted code already holds the new key when the deferred press fires.
  assign code_d    = state_q == ST_PEND ? acode_q : new_press ? f_code : code_q;
  assign acls_d    = upd ? f_cls : acls_q;
  assign acode_d   = upd ? f_code : acode_q;
  assign pcls_d    = eval ? f_cls : pcls_q;
  assign pcode_d   = eval ? f_code : pcode_q;
  assign stab_d    = eval ? stab_n : stab_q;
  assign cnt_d     = state_q != ST_SCAN ? cnt_q : cnt_q == LAST_CNT ? '0 : cnt_q + CNT_W'(1);
  assign row_d     = sample ? (row_q == LAST_ROW ? '0 : row_q + ROW_W'(1)) : row_q;
  assign state_d   = state_q == ST_SCAN ? (sample && row_q == LAST_ROW ? ST_EVAL : ST_SCAN)
                   : roll ? ST_PEND : ST_SCAN;

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      row_q   <= '0;
      run_q   <= 1'b0;
      nk_q    <= '0;
      fc_q    <= '0;
      pcls_q  <= CLS_NONE;
      pcode_q <= '0;
      acls_q  <= CLS_NONE;
      acode_q <= '0;
      stab_q  <= '0;
      code_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      run_q   <= 1'b1;
      nk_q    <= nk_d;
      fc_q    <= fc_d;
      pcls_q  <= pcls_d;
      pcode_q <= pcode_d;
      acls_q  <= acls_d;
      acode_q <= acode_d;
      stab_q  <= stab_d;
      code_q  <= code_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end

  assign row_n       = run_q ? ~(ROWS'(1) << row_q) : '1;
  assign key_code    = code_q;
  assign key_valid   = acls_q == CLS_SINGLE;
  assign multi_key   = acls_q == CLS_MULTI;
  assign key_press   = press_q;
  assign key_release = rel_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix model driving the scanner; expected events queued, monitor pops and compares.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid, key_press, key_release, multi_key;
  logic [15:0] keys = '0;

  typedef struct {
    logic       is_press;
    logic [3:0] code;
    logic       vld;
    logic       adj;
  } ev_t;
  ev_t sb[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int last_ev = -10;
  logic roll_win = 1'b0;
  logic roll_drop = 1'b0;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_press(key_press), .key_release(key_release), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push(input logic p, input logic [3:0] code, input logic vld, input logic adj);
    ev_t e;
    e.is_press = p;
    e.code = code;
    e.vld = vld;
    e.adj = adj;
    sb.push_back(e);
  endtask

  task automatic wait_pulse(input logic p, input int n, input string name);
    int k;
    k = 0;
    while (!(p ? key_press : key_release) && k < n) begin
      @(negedge clk);
      k++;
    end
    chk(name, p ? key_press : key_release, 1'b1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (key_press === 1'b1 && key_release === 1'b1) begin
      total_cnt++;
      $display("FAIL press_and_release_together actual=11 required=one");
    end else if (key_press === 1'b1 || key_release === 1'b1) begin
      total_cnt++;
      if (sb.size() == 0)
        $display("FAIL unexpected_event actual=press%0b/code%0d required=none", key_press, key_code);
      else begin
        e = sb.pop_front();
        if (e.is_press !== key_press || e.code !== key_code || e.vld !== key_valid
            || (e.adj && cyc != last_ev + 1))
          $display("FAIL event actual=press%0b/code%0d/valid%0b/gap%0d required=press%0b/code%0d/valid%0b/adj%0b",
                   key_press, key_code, key_valid, cyc - last_ev, e.is_press, e.code, e.vld, e.adj);
        else pass_cnt++;
      end
      last_ev = cyc;
    end
    if (roll_win && !key_valid) roll_drop = 1'b1;
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_row_n", row_n, 4'b1111);
    chk("reset_outputs", {key_code, key_valid, key_press, key_release, multi_key}, '0);
    rst_n = 1'b1;
    keys = 16'h1 << 9;
    @(negedge clk);
    chk("release_row_n", row_n, 4'b1110);
    push(1'b1, 4'd9, 1'b1, 1'b0);
    wait_pulse(1'b1, 161, "press9_latency");
    repeat (300) @(negedge clk);
    chk("held9_valid", {key_valid, multi_key}, 2'b10);
    push(1'b0, 4'd9, 1'b0, 1'b0);
    keys = '0;
    repeat (250) @(negedge clk);
    chk("released9_valid", {key_valid, key_code}, {1'b0, 4'd9});

    for (int i = 0; i < 10; i++) begin
      keys[5] = ~keys[5];
      repeat (30) @(negedge clk);
    end
    keys = '0;
    repeat (200) @(negedge clk);
    chk("bounce_no_valid", key_valid, 1'b0);

    push(1'b1, 4'd0, 1'b1, 1'b0);
    keys = 16'h0001;
    repeat (250) @(negedge clk);
    roll_win = 1'b1;
    push(1'b0, 4'd0, 1'b1, 1'b0);
    push(1'b1, 4'd15, 1'b1, 1'b1);
    keys = 16'h8000;
    repeat (250) @(negedge clk);
    roll_win = 1'b0;
    chk("roll_valid_held", roll_drop, 1'b0);
    chk("roll_code", key_code, 4'd15);
    push(1'b0, 4'd15, 1'b0, 1'b0);
    keys = '0;
    repeat (250) @(negedge clk);

    keys = (16'h1 << 3) | (16'h1 << 6);
    repeat (250) @(negedge clk);
    chk("multi_held", {multi_key, key_valid}, 2'b10);
    push(1'b1, 4'd3, 1'b1, 1'b0);
    keys = 16'h1 << 3;
    repeat (250) @(negedge clk);
    chk("multi_to_single", {multi_key, key_valid, key_code}, {2'b01, 4'd3});
    push(1'b0, 4'd3, 1'b0, 1'b0);
    keys = '0;
    repeat (250) @(negedge clk);

    push(1'b1, 4'd0, 1'b1, 1'b0);
    keys = 16'h0001;
    repeat (250) @(negedge clk);
    push(1'b0, 4'd0, 1'b1, 1'b0);
    keys = 16'h8000;
    wait_pulse(1'b0, 250, "pend_release_seen");
    rst_n = 1'b0;
    keys = '0;
    @(negedge clk);
    chk("pend_reset_outputs", {key_code, key_valid, key_press, key_release, multi_key}, '0);
    chk("pend_reset_row_n", row_n, 4'b1111);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_reset_idle", {key_valid, multi_key}, 2'b00);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
